// File: rtl/fifo_to_sdram_packer_if.sv
// Bundle of control, Avalon-MM write and FIFO read signals for the SDRAM image loader.
// master: the packer side; slave: the surrounding system (FIFO, SDRAM, controller).
interface fifo_to_sdram_packer_if #(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 25,
    parameter int IMG_BITS = 19,
    parameter int ID_W     = 6,
    parameter int NUM_W    = 7
);
    logic                      iTRIGGER;
    logic                      iABORT;
    logic                      iBYTE_ORDER;
    logic [NUM_W-1:0]          iNUM_IMAGES;
    logic [ID_W-1:0]           iID_OF_STARTING_IMAGE;
    logic                      iWAIT_REQUEST;
    logic                      oWR_REQ;
    logic [DATA_W-1:0]         oWR_DATA;
    logic [ADDR_W-1:0]         oWR_ADDR;
    logic                      oDONE;
    logic                      oBUSY;
    logic [NUM_W+IMG_BITS-1:0] oWORDS_WRITTEN;
    logic                      oFIFO_RD_CLK;
    logic                      oFIFO_RD_REQ;
    logic [BYTE_W-1:0]         iFIFO_RD_DATA;
    logic                      iFIFO_RD_EMPTY;

    modport master (
        input  iTRIGGER, iABORT, iBYTE_ORDER, iNUM_IMAGES, iID_OF_STARTING_IMAGE,
               iWAIT_REQUEST, iFIFO_RD_DATA, iFIFO_RD_EMPTY,
        output oWR_REQ, oWR_DATA, oWR_ADDR, oDONE, oBUSY, oWORDS_WRITTEN,
               oFIFO_RD_CLK, oFIFO_RD_REQ
    );

    modport slave (
        output iTRIGGER, iABORT, iBYTE_ORDER, iNUM_IMAGES, iID_OF_STARTING_IMAGE,
               iWAIT_REQUEST, iFIFO_RD_DATA, iFIFO_RD_EMPTY,
        input  oWR_REQ, oWR_DATA, oWR_ADDR, oDONE, oBUSY, oWORDS_WRITTEN,
               oFIFO_RD_CLK, oFIFO_RD_REQ
    );
endinterface

// File: rtl/fifo_to_sdram_packer.sv
// Drains a byte FIFO, packs DATA_W/BYTE_W bytes per SDRAM word and writes consecutive
// image slots over Avalon-MM single-word writes.
module fifo_to_sdram_packer #(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 25,
    parameter int IMG_BITS = 19,
    parameter int ID_W     = 6,
    parameter int NUM_W    = 7
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    fifo_to_sdram_packer_if.master bus
);
    localparam int R     = DATA_W / BYTE_W;
    localparam int CNT_W = $clog2(R + 1);
    localparam int WW    = NUM_W + IMG_BITS;
    localparam logic [CNT_W-1:0] R_C    = CNT_W'(R);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(R - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SLAVE, S_FETCH, S_WRITE, S_DONE} state_t;

    state_t              state_q;
    logic [NUM_W-1:0]    left_q;
    logic [ID_W-1:0]     id_q;
    logic [IMG_BITS-1:0] offset_q;
    logic                order_q;
    logic                abort_pend_q;
    logic [CNT_W-1:0]    req_cnt_q;
    logic [CNT_W-1:0]    rcv_cnt_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   pack_q;
    logic [DATA_W-1:0]   pack_d;
    logic                wr_req_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WW-1:0]       words_q;
    logic                done_q;

    logic rd_req, rx_valid, word_full, offset_wrap, last_word;

    // Read strobe follows EMPTY combinationally so a non-empty FIFO streams one byte per cycle.
    assign rd_req      = (state_q == S_FETCH) & ~bus.iFIFO_RD_EMPTY & (req_cnt_q < R_C);
    assign rx_valid    = (state_q == S_FETCH) & rd_pend_q;
    assign word_full   = rx_valid & (rcv_cnt_q == LAST_C);
    assign offset_wrap = &offset_q;
    assign last_word   = offset_wrap & (left_q == NUM_W'(1));

    // Lane k (arrival order) lands in chunk R-1-k for MSB-first, chunk k for LSB-first.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_lane
            localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(R - 1 - gi);
            localparam logic [CNT_W-1:0] LSB_IDX = CNT_W'(gi);
            logic hit;
            assign hit = rx_valid & (rcv_cnt_q == (order_q ? LSB_IDX : MSB_IDX));
            assign pack_d[gi*BYTE_W +: BYTE_W] = hit ? bus.iFIFO_RD_DATA
                                                     : pack_q[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            left_q       <= '0;
            id_q         <= '0;
            offset_q     <= '0;
            order_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            req_cnt_q    <= '0;
            rcv_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            pack_q       <= '0;
            wr_req_q     <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            words_q      <= '0;
            done_q       <= 1'b1;
        end else begin
            rd_pend_q <= rd_req;
            case (state_q)
                S_IDLE: begin
                    if (bus.iTRIGGER) begin
                        left_q       <= bus.iNUM_IMAGES;
                        id_q         <= bus.iID_OF_STARTING_IMAGE;
                        order_q      <= bus.iBYTE_ORDER;
                        offset_q     <= '0;
                        abort_pend_q <= 1'b0;
                        words_q      <= '0;
                        req_cnt_q    <= '0;
                        rcv_cnt_q    <= '0;
                        if (bus.iNUM_IMAGES == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT_SLAVE;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_WAIT_SLAVE: begin
                    if (bus.iABORT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (!bus.iWAIT_REQUEST) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.iABORT) begin
                        // Partial word is dropped; an in-flight byte arrives in DONE and is ignored.
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        req_cnt_q <= '0;
                        rcv_cnt_q <= '0;
                    end else begin
                        if (rd_req)
                            req_cnt_q <= req_cnt_q + CNT_W'(1);
                        if (rx_valid) begin
                            rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
                            pack_q    <= pack_d;
                        end
                        if (word_full) begin
                            wr_data_q <= pack_d;
                            wr_addr_q <= ADDR_W'({id_q, offset_q});
                            wr_req_q  <= 1'b1;
                            req_cnt_q <= '0;
                            rcv_cnt_q <= '0;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.iABORT)
                        abort_pend_q <= 1'b1;
                    if (!bus.iWAIT_REQUEST) begin
                        wr_req_q <= 1'b0;
                        words_q  <= words_q + WW'(1);
                        offset_q <= offset_q + IMG_BITS'(1);
                        if (offset_wrap) begin
                            id_q   <= id_q + ID_W'(1);
                            left_q <= left_q - NUM_W'(1);
                        end
                        if (last_word || abort_pend_q || bus.iABORT) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.iTRIGGER)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oWR_REQ        = wr_req_q;
    assign bus.oWR_DATA       = wr_data_q;
    assign bus.oWR_ADDR       = wr_addr_q;
    assign bus.oDONE          = done_q;
    assign bus.oBUSY          = ~done_q;
    assign bus.oWORDS_WRITTEN = words_q;
    assign bus.oFIFO_RD_CLK   = iCLK;
    assign bus.oFIFO_RD_REQ   = rd_req;
endmodule
